// File: rtl/de10_mmio_bridge.sv
// Load/store bridge from the core LSU to the de10 peripheral register port.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module de10_mmio_bridge #(
  parameter logic [7:0] PERIPH_BASE_HI = 8'hF0,
  parameter int         IDX_LEN        = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] p_addr,
  output logic        p_wr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic        uns_reg;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [31:0] p_addr_reg;

  logic        req_err;
  logic [31:0] wdata_rep;
  logic [3:0]  byte_sel;
  logic [31:0] merged;
  logic [31:0] loaded;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign req_err = (req_addr[31:24] != PERIPH_BASE_HI)
                 || (req_size == 2'd3)
                 || ((req_size == 2'd1) && req_addr[0])
                 || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err)
            state_next = RESP;
          else if (!req_we || (req_size != 2'd2))
            state_next = READ;
          else
            state_next = WRITE;
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store data replicated across lanes so each byte lane can pick its own copy.
  always_comb begin
    wdata_rep = wdata_reg;
    case (size_reg)
      2'd0:    wdata_rep = {4{wdata_reg[7:0]}};
      2'd1:    wdata_rep = {2{wdata_reg[15:0]}};
      default: wdata_rep = wdata_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign byte_sel[gi] = (size_reg == 2'd0) ? (lane_reg == LANE) :
                            (size_reg == 2'd1) ? (lane_reg[1] == LANE[1]) : 1'b1;
      assign merged[8*gi +: 8] = byte_sel[gi] ? wdata_rep[8*gi +: 8] : p_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_byte = 8'(p_rdata >> {lane_reg, 3'b000});
    load_half = 16'(p_rdata >> {lane_reg[1], 4'b0000});
    case (size_reg)
      2'd0:    loaded = {{24{load_byte[7] & ~uns_reg}}, load_byte};
      2'd1:    loaded = {{16{load_half[15] & ~uns_reg}}, load_half};
      default: loaded = p_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      uns_reg    <= 1'b0;
      size_reg   <= 2'd0;
      lane_reg   <= 2'd0;
      wdata_reg  <= '0;
      word_reg   <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      p_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            uns_reg   <= req_unsigned;
            size_reg  <= req_size;
            lane_reg  <= req_addr[1:0];
            wdata_reg <= req_wdata;
            word_reg  <= req_wdata;
            err_reg   <= req_err;
            rdata_reg <= '0;
            // Rejected requests leave the peripheral address untouched.
            if (!req_err)
              p_addr_reg <= {{(32-IDX_LEN){1'b0}}, req_addr[IDX_LEN+1:2]};
          end
        end
        READ: begin
          if (we_reg)
            word_reg <= merged;
          else
            rdata_reg <= loaded;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign p_addr     = p_addr_reg;
  assign p_wdata    = word_reg;
  // A reset landing on the WRITE cycle must not let the peripheral commit it.
  assign p_wr       = (state_reg == WRITE) && !rst;

endmodule

// File: tb/tb_de10_mmio_bridge.sv
// Self-checking bench for de10_mmio_bridge with a small peripheral memory
// and an arithmetic reference model of the load/store semantics.
module tb_de10_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] p_addr;
  logic        p_wr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] pmem [16];
  logic [31:0] mmem [16];
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [31:0] load_val = '0;
  int          wr_count = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;

  de10_mmio_bridge #(.PERIPH_BASE_HI(8'hF0), .IDX_LEN(22)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .p_addr(p_addr), .p_wr(p_wr), .p_wdata(p_wdata), .p_rdata(p_rdata)
  );

  always #5 clk = ~clk;

  // Peripheral: combinational read, write committed on a clock edge with wr high.
  assign p_rdata = pmem[p_addr[3:0]];
  always @(posedge clk) begin
    if (load_en) begin
      pmem[load_idx] <= load_val;
    end else if (p_wr) begin
      pmem[p_addr[3:0]] <= p_wdata;
      wr_count <= wr_count + 1;
      wr_addr  <= p_addr;
      wr_data  <= p_wdata;
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    load_idx = 4'(idx);
    load_val = val;
    load_en  = 1'b1;
    mmem[idx] = val;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Reference: byte-addressed access semantics expressed with plain arithmetic.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output int lat,
                                output int nwr, output logic [31:0] wdat);
    logic [31:0] nb, mask, word, val;
    int sh;
    nb   = 32'd1 << size;
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    err  = (addr[31:24] != 8'hF0) || (size == 2'd3) || ((addr % nb) != 0);
    rd = '0; lat = 1; nwr = 0; wdat = '0;
    if (err) return;
    word = mmem[addr[5:2]];
    sh   = 8 * int'(addr % 4);
    if (!we) begin
      val = (word >> sh) & mask;
      if (!uns && val[8*nb-1]) val = val | ~mask;
      rd  = val;
      lat = 2;
    end else begin
      wdat = (word & ~(mask << sh)) | ((wd & mask) << sh);
      mmem[addr[5:2]] = wdat;
      nwr = 1;
      lat = (size == 2'd2) ? 2 : 3;
    end
  endfunction

  task automatic rand_req(output logic we, output logic [31:0] addr, output logic [1:0] size,
                          output logic uns, output logic [31:0] wd);
    int r;
    r    = $urandom_range(0, 9);
    size = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    addr = {8'hF0, 24'($urandom)};
    if (r == 1) addr[31:24] = 8'($urandom_range(0, 239));
    if (r >= 3 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
    we  = 1'($urandom_range(0, 1));
    uns = 1'($urandom_range(0, 1));
    wd  = $urandom;
  endtask

  // Drives one request from IDLE and collects what the bridge did with it.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic err,
                       output int nwr, output logic [31:0] pa1);
    int  w0;
    bit  seen;
    @(negedge clk);
    w0 = wr_count;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; rd = '0; err = 1'b0; pa1 = '0; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) pa1 = p_addr;
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!seen) lat = -1;
    nwr = wr_count - w0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (p_wr !== 1'b0) begin errors++; $display("FAIL reset_p_wr got %b want 0", p_wr); end
    checks++; if (p_addr !== 32'h0) begin errors++; $display("FAIL reset_p_addr got %h want 0", p_addr); end
    checks++; if (p_wdata !== 32'h0) begin errors++; $display("FAIL reset_p_wdata got %h want 0", p_wdata); end
    $display("reset: ready=%b resp_valid=%b p_addr=%h", req_ready, resp_valid, p_addr);
  endtask

  task automatic test_word_store;
    int lat, nwr; logic [31:0] rd, pa1; logic err;
    issue(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_03FF, lat, rd, err, nwr, pa1);
    mmem[0] = 32'h0000_03FF;
    $display("word_store: lat=%0d err=%b writes=%0d waddr=%h wdata=%h", lat, err, nwr, wr_addr, wr_data);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ws_latency got %0d want 2", lat); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL ws_resp got err=%b rd=%h want 0/0", err, rd); end
    checks++; if (nwr !== 1) begin errors++; $display("FAIL ws_write_count got %0d want 1", nwr); end
    checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0000_03FF) begin
      errors++; $display("FAIL ws_write got %h/%h want 00000000/000003ff", wr_addr, wr_data); end
  endtask

  task automatic test_byte_store;
    int lat, nwr; logic [31:0] rd, pa1; logic err;
    preload(1, 32'h1122_3344);
    issue(1'b1, 32'hF000_0005, 2'd0, 1'b0, 32'h0000_00A5, lat, rd, err, nwr, pa1);
    mmem[1] = 32'h1122_A544;
    $display("byte_store: lat=%0d read_addr=%h writes=%0d wdata=%h", lat, pa1, nwr, wr_data);
    checks++; if (pa1 !== 32'h1) begin errors++; $display("FAIL bs_read_addr got %h want 1", pa1); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bs_latency got %0d want 3", lat); end
    checks++; if (nwr !== 1) begin errors++; $display("FAIL bs_write_count got %0d want 1", nwr); end
    checks++; if (wr_addr !== 32'h1 || wr_data !== 32'h1122_A544) begin
      errors++; $display("FAIL bs_write got %h/%h want 00000001/1122a544", wr_addr, wr_data); end
  endtask

  task automatic test_half_load;
    int lat, nwr; logic [31:0] rd, pa1; logic err;
    preload(0, 32'h8001_0000);
    issue(1'b0, 32'hF000_0002, 2'd1, 1'b0, 32'h0, lat, rd, err, nwr, pa1);
    $display("half_load signed: lat=%0d rdata=%h writes=%0d", lat, rd, nwr);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL hl_signed got %h want ffff8001", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL hl_latency got %0d want 2", lat); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL hl_signed_wr got %0d want 0", nwr); end
    issue(1'b0, 32'hF000_0002, 2'd1, 1'b1, 32'h0, lat, rd, err, nwr, pa1);
    $display("half_load unsigned: lat=%0d rdata=%h writes=%0d", lat, rd, nwr);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL hl_unsigned got %h want 00008001", rd); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL hl_unsigned_wr got %0d want 0", nwr); end
  endtask

  task automatic test_errors;
    int lat, nwr; logic [31:0] rd, pa1; logic err;
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    logic        wes   [4];
    addrs = '{32'hF000_0002, 32'h0000_1000, 32'h0000_1000, 32'hF000_0001};
    sizes = '{2'd2, 2'd2, 2'd0, 2'd1};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], addrs[i], sizes[i], 1'b0, 32'hDEAD_BEEF, lat, rd, err, nwr, pa1);
      $display("error_case %0d: addr=%h size=%0d lat=%0d err=%b rdata=%h writes=%0d",
               i, addrs[i], sizes[i], lat, err, rd, nwr);
      checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_%0d got err=%b lat=%0d want 1/1", i, err, lat); end
      checks++; if (nwr !== 0 || rd !== 32'h0) begin errors++; $display("FAIL err_side_%0d got wr=%0d rd=%h want 0/0", i, nwr, rd); end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, nwr, w0; logic [31:0] rd, pa1; logic err;
    preload(1, 32'hCAFE_BABE);
    w0 = wr_count;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'hF000_0004; req_size = 2'd1; req_unsigned = 1'b0;
    req_wdata = 32'h0000_1234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (p_wr !== 1'b0) begin errors++; $display("FAIL rmw_p_wr_in_reset got %b want 0", p_wr); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("reset_mid_write: ready=%b resp_valid=%b p_wr=%b p_addr=%h", req_ready, resp_valid, p_wr, p_addr);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || p_wr !== 1'b0) begin
      errors++; $display("FAIL rmw_ctrl got ready=%b valid=%b wr=%b want 1/0/0", req_ready, resp_valid, p_wr); end
    checks++; if (p_addr !== 32'h0 || p_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rmw_data got %h/%h/%h/%b want zeros", p_addr, p_wdata, resp_rdata, resp_err); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmw_stray_resp got %b want 0", resp_valid); end
    end
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL rmw_no_write got %0d want %0d", wr_count - w0, 0); end
    issue(1'b0, 32'hF000_0004, 2'd2, 1'b0, 32'h0, lat, rd, err, nwr, pa1);
    $display("post_reset load: lat=%0d rdata=%h err=%b", lat, rd, err);
    checks++; if (rd !== 32'hCAFE_BABE || err !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL rmw_next_load got %h/%b/%0d want cafebabe/0/2", rd, err, lat); end
  endtask

  task automatic test_random;
    int lat, nwr, elat, enwr; logic [31:0] rd, pa1, erd, ewd, addr, wd; logic err, eerr, we, uns;
    logic [1:0] size;
    for (int n = 0; n < 40; n++) begin
      rand_req(we, addr, size, uns, wd);
      model(we, addr, size, uns, wd, eerr, erd, elat, enwr, ewd);
      issue(we, addr, size, uns, wd, lat, rd, err, nwr, pa1);
      $display("rand %0d: we=%b addr=%h size=%0d uns=%b lat=%0d err=%b rdata=%h writes=%0d",
               n, we, addr, size, uns, lat, err, rd, nwr);
      checks++;
      if (err !== eerr || rd !== erd || lat !== elat || nwr !== enwr) begin
        errors++;
        $display("FAIL rand_%0d got err=%b rd=%h lat=%0d wr=%0d want %b/%h/%0d/%0d",
                 n, err, rd, lat, nwr, eerr, erd, elat, enwr);
      end
      if (!eerr) begin
        checks++;
        if (pa1 !== {10'b0, addr[23:2]}) begin errors++; $display("FAIL rand_paddr_%0d got %h want %h", n, pa1, {10'b0, addr[23:2]}); end
      end
      if (enwr == 1) begin
        checks++;
        if (wr_data !== ewd) begin errors++; $display("FAIL rand_wdata_%0d got %h want %h", n, wr_data, ewd); end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int n = 0, done = 0, cyc = 0, w0, nst = 0, elat, enwr;
    logic busy = 1'b0, acc, eerr, we, uns;
    logic [31:0] erd, ewd, addr, wd;
    logic [1:0] size;
    w0 = wr_count;
    @(negedge clk);
    rand_req(we, addr, size, uns, wd);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    for (int c = 0; c < 400 && done < 12; c++) begin
      if (resp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_resp got 1 want 0");
        end else begin
          e = q.pop_front();
          $display("b2b resp %0d: err=%b rdata=%h lat=%0d", done, resp_err, resp_rdata, cyc - e.acc + 1);
          if (resp_err !== e.err || resp_rdata !== e.rd || (cyc - e.acc + 1) !== e.lat) begin
            errors++;
            $display("FAIL b2b_resp_%0d got %b/%h/%0d want %b/%h/%0d",
                     done, resp_err, resp_rdata, cyc - e.acc + 1, e.err, e.rd, e.lat);
          end
        end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp got %b want 0", req_ready); end
        done++;
        busy = 1'b0;
      end else if (busy) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b want 0", req_ready); end
      end
      acc = req_valid && req_ready;
      if (acc) begin
        model(req_we, req_addr, req_size, req_unsigned, req_wdata, eerr, erd, elat, enwr, ewd);
        e.err = eerr; e.rd = erd; e.lat = elat;
        nst += enwr;
      end
      @(posedge clk);
      cyc++;
      if (acc) begin
        e.acc = cyc;
        q.push_back(e);
        busy = 1'b1;
        n++;
        #1;
        if (n < 12) begin
          rand_req(we, addr, size, uns, wd);
          req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (done !== 12 || q.size() !== 0) begin errors++; $display("FAIL b2b_count got %0d want 12", done); end
    checks++; if (wr_count - w0 !== nst) begin errors++; $display("FAIL b2b_writes got %0d want %0d", wr_count - w0, nst); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (pmem[i] !== mmem[i]) begin errors++; $display("FAIL b2b_mem_%0d got %h want %h", i, pmem[i], mmem[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    test_word_store();
    test_byte_store();
    test_half_load();
    test_errors();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
